// File: rtl/flip_select_sequencer.sv
// Sequences one flip decision: fetches each literal's broken/mask bits, presents them to
// the flip selector, issues the use cycle, and returns the chosen variable. Optional macro:
// FLIP_SEQ_TIMEOUT_EN adds a memory watchdog that treats a silent literal as padded.
module flip_select_sequencer #(
    parameter int NSAT                     = 3,
    parameter int MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int VAR_BITS                 = 10,
    parameter int TIMEOUT_CYCLES           = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start_i,
    output logic                                start_ready_o,
    input  logic [NSAT*VAR_BITS-1:0]            clause_vars_i,
    output logic                                mem_req_o,
    output logic [VAR_BITS-1:0]                 mem_addr_o,
    input  logic                                mem_rvalid_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_mask_i,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] vfs_broken_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] vfs_mask_o,
    output logic [NSAT-1:0]                     vfs_valid_o,
    output logic [$clog2(NSAT)-1:0]             vfs_wren_o,
    input  logic [$clog2(NSAT)-1:0]             vfs_selected_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] vfs_broken_bits_i,
    output logic                                done_valid_o,
    input  logic                                done_ready_i,
    output logic [VAR_BITS-1:0]                 done_var_o,
    output logic [$clog2(NSAT)-1:0]             done_row_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] done_broken_bits_o
);

    localparam int NB = $clog2(NSAT);
    localparam int MC = MAX_CLAUSES_PER_VARIABLE;

    // The selector's wren code space only distinguishes three rows plus the use cycle.
    if (NSAT != 3) begin : g_bad_nsat
        $error("flip_select_sequencer: NSAT must be 3");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("flip_select_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [NB-1:0]            idx_q, idx_d;
    logic [NSAT*VAR_BITS-1:0] vars_q, vars_d;
    logic [NSAT-1:0]          valid_q, valid_d;
    logic [MC-1:0]            broken_q, broken_d;
    logic [MC-1:0]            mask_q, mask_d;
    logic [NB-1:0]            wren_q, wren_d;
    logic                     mem_req_q, mem_req_d;
    logic [VAR_BITS-1:0]      mem_addr_q, mem_addr_d;
    logic                     start_ready_q, start_ready_d;
    logic                     done_valid_q, done_valid_d;
    logic [VAR_BITS-1:0]      done_var_q, done_var_d;
    logic [NB-1:0]            done_row_q, done_row_d;
    logic [MC-1:0]            done_bb_q, done_bb_d;
    logic                     no_cand_q, no_cand_d;

    logic                     go_lit;
    logic [NB-1:0]            lit_idx;
    logic [VAR_BITS-1:0]      lit_var;
    logic                     enter_present;

`ifdef FLIP_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        vars_d        = vars_q;
        valid_d       = valid_q;
        broken_d      = broken_q;
        mask_d        = mask_q;
        wren_d        = '0;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        start_ready_d = start_ready_q;
        done_valid_d  = done_valid_q;
        done_var_d    = done_var_q;
        done_row_d    = done_row_q;
        done_bb_d     = done_bb_q;
        no_cand_d     = no_cand_q;
        go_lit        = 1'b0;
        lit_idx       = '0;
        lit_var       = '0;
        enter_present = 1'b0;
`ifdef FLIP_SEQ_TIMEOUT_EN
        timer_d       = timer_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i && start_ready_q) begin
                    vars_d        = clause_vars_i;
                    valid_d       = '0;
                    no_cand_d     = 1'b0;
                    start_ready_d = 1'b0;
                    go_lit        = 1'b1;
                    lit_idx       = '0;
                end
            end

            S_FETCH: begin
                if (mem_rvalid_i) begin
                    mem_req_d      = 1'b0;
                    broken_d       = mem_broken_i;
                    mask_d         = mem_mask_i;
                    valid_d[idx_q] = 1'b1;
                    state_d        = S_PRESENT;
                    enter_present  = 1'b1;
                end
`ifdef FLIP_SEQ_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Memory cancels once the request drops; the literal degrades to padding.
                    mem_req_d     = 1'b0;
                    broken_d      = '0;
                    mask_d        = '0;
                    state_d       = S_PRESENT;
                    enter_present = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end

            S_PRESENT: begin
                if (idx_q == NB'(NSAT - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    go_lit  = 1'b1;
                    lit_idx = idx_q + NB'(1);
                end
            end

            S_CAPTURE: begin
                state_d      = S_DONE;
                done_valid_d = 1'b1;
                if (no_cand_q || (int'(vfs_selected_i) >= NSAT)) begin
                    done_var_d = '0;
                    done_row_d = NB'(NSAT);
                    done_bb_d  = '0;
                end else begin
                    done_var_d = vars_q[int'(vfs_selected_i)*VAR_BITS +: VAR_BITS];
                    done_row_d = vfs_selected_i;
                    done_bb_d  = vfs_broken_bits_i;
                end
            end

            S_DONE: begin
                if (done_ready_i) begin
                    done_valid_d  = 1'b0;
                    start_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Step to literal lit_idx: padded literals skip the memory entirely.
        if (go_lit) begin
            lit_var = vars_d[int'(lit_idx)*VAR_BITS +: VAR_BITS];
            idx_d   = lit_idx;
            if (lit_var == '0) begin
                broken_d      = '0;
                mask_d        = '0;
                state_d       = S_PRESENT;
                enter_present = 1'b1;
            end else begin
                state_d    = S_FETCH;
                mem_req_d  = 1'b1;
                mem_addr_d = lit_var;
`ifdef FLIP_SEQ_TIMEOUT_EN
                timer_d    = '0;
`endif
            end
        end

        // Last row doubles as the use cycle, unless nothing valid was ever loaded.
        if (enter_present) begin
            if (idx_d == NB'(NSAT - 1)) begin
                if (valid_d == '0) begin
                    wren_d    = '0;
                    no_cand_d = 1'b1;
                end else begin
                    wren_d = '1;
                end
            end else begin
                wren_d = NB'(1) << idx_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            vars_q        <= '0;
            valid_q       <= '0;
            broken_q      <= '0;
            mask_q        <= '0;
            wren_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            done_var_q    <= '0;
            done_row_q    <= NB'(NSAT);
            done_bb_q     <= '0;
            no_cand_q     <= 1'b0;
`ifdef FLIP_SEQ_TIMEOUT_EN
            timer_q       <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            idx_q         <= idx_d;
            vars_q        <= vars_d;
            valid_q       <= valid_d;
            broken_q      <= broken_d;
            mask_q        <= mask_d;
            wren_q        <= wren_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            start_ready_q <= start_ready_d;
            done_valid_q  <= done_valid_d;
            done_var_q    <= done_var_d;
            done_row_q    <= done_row_d;
            done_bb_q     <= done_bb_d;
            no_cand_q     <= no_cand_d;
`ifdef FLIP_SEQ_TIMEOUT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    assign start_ready_o      = start_ready_q;
    assign mem_req_o          = mem_req_q;
    assign mem_addr_o         = mem_addr_q;
    assign vfs_broken_o       = broken_q;
    assign vfs_mask_o         = mask_q;
    assign vfs_valid_o        = valid_q;
    assign vfs_wren_o         = wren_q;
    assign done_valid_o       = done_valid_q;
    assign done_var_o         = done_var_q;
    assign done_row_o         = done_row_q;
    assign done_broken_bits_o = done_bb_q;

endmodule

// File: tb/tb_flip_select_sequencer.sv
// Directed bench for flip_select_sequencer: cycle-exact checks of fetch, present, use,
// capture and handshake behaviour, plus the watchdog path when FLIP_SEQ_TIMEOUT_EN is set.
module tb_flip_select_sequencer;

    localparam int NSAT = 3;
    localparam int MC   = 20;
    localparam int VB   = 10;
    localparam int NB   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_i;
    logic               start_ready_o;
    logic [NSAT*VB-1:0] clause_vars_i;
    logic               mem_req_o;
    logic [VB-1:0]      mem_addr_o;
    logic               mem_rvalid_i;
    logic [MC-1:0]      mem_broken_i;
    logic [MC-1:0]      mem_mask_i;
    logic [MC-1:0]      vfs_broken_o;
    logic [MC-1:0]      vfs_mask_o;
    logic [NSAT-1:0]    vfs_valid_o;
    logic [NB-1:0]      vfs_wren_o;
    logic [NB-1:0]      vfs_selected_i;
    logic [MC-1:0]      vfs_broken_bits_i;
    logic               done_valid_o;
    logic               done_ready_i;
    logic [VB-1:0]      done_var_o;
    logic [NB-1:0]      done_row_o;
    logic [MC-1:0]      done_broken_bits_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    flip_select_sequencer #(
        .NSAT                     (NSAT),
        .MAX_CLAUSES_PER_VARIABLE (MC),
        .VAR_BITS                 (VB),
        .TIMEOUT_CYCLES           (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start_i            (start_i),
        .start_ready_o      (start_ready_o),
        .clause_vars_i      (clause_vars_i),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_broken_i       (mem_broken_i),
        .mem_mask_i         (mem_mask_i),
        .vfs_broken_o       (vfs_broken_o),
        .vfs_mask_o         (vfs_mask_o),
        .vfs_valid_o        (vfs_valid_o),
        .vfs_wren_o         (vfs_wren_o),
        .vfs_selected_i     (vfs_selected_i),
        .vfs_broken_bits_i  (vfs_broken_bits_i),
        .done_valid_o       (done_valid_o),
        .done_ready_i       (done_ready_i),
        .done_var_o         (done_var_o),
        .done_row_o         (done_row_o),
        .done_broken_bits_o (done_broken_bits_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input logic [VB-1:0] v2, input logic [VB-1:0] v1, input logic [VB-1:0] v0);
        clause_vars_i = {v2, v1, v0};
        start_i       = 1'b1;
        cyc           = 0;
        step();
        start_i       = 1'b0;
        clause_vars_i = '1;
    endtask

    // Serve one fetch with latency lat; returns in the PRESENT cycle of that literal.
    task automatic serve(input string tag, input logic [VB-1:0] addr, input int lat,
                         input logic [MC-1:0] broken, input logic [MC-1:0] mask);
        check({tag, "_req"}, 64'(mem_req_o), 64'(1));
        check({tag, "_addr"}, 64'(mem_addr_o), 64'(addr));
        for (int i = 0; i < lat; i++) begin
            step();
            check({tag, "_req_hold"}, 64'(mem_req_o), 64'(1));
        end
        mem_rvalid_i = 1'b1;
        mem_broken_i = broken;
        mem_mask_i   = mask;
        step();
        mem_rvalid_i = 1'b0;
        mem_broken_i = '0;
        mem_mask_i   = '0;
        check({tag, "_req_drop"}, 64'(mem_req_o), 64'(0));
        check({tag, "_broken"}, 64'(vfs_broken_o), 64'(broken));
        check({tag, "_mask"}, 64'(vfs_mask_o), 64'(mask));
    endtask

    initial begin
        reset             = 1'b1;
        start_i           = 1'b0;
        clause_vars_i     = '0;
        mem_rvalid_i      = 1'b0;
        mem_broken_i      = '0;
        mem_mask_i        = '0;
        vfs_selected_i    = '0;
        vfs_broken_bits_i = '0;
        done_ready_i      = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_start_ready", 64'(start_ready_o), 64'(1));
        check("rst_mem_req", 64'(mem_req_o), 64'(0));
        check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
        check("rst_vfs_valid", 64'(vfs_valid_o), 64'(0));
        check("rst_vfs_wren", 64'(vfs_wren_o), 64'(0));
        check("rst_done_valid", 64'(done_valid_o), 64'(0));
        check("rst_done_row", 64'(done_row_o), 64'(3));

        // Vars {5,9,12}, L=1, selector picks row 1
        accept(10'd12, 10'd9, 10'd5);
        check("t1_start_ready_low", 64'(start_ready_o), 64'(0));
        serve("t1_l0", 10'd5, 1, 20'h00011, 20'h000F1);
        check("t1_cyc3", 64'(cyc), 64'(3));
        check("t1_wren0", 64'(vfs_wren_o), 64'(2'b01));
        step();
        serve("t1_l1", 10'd9, 1, 20'h00022, 20'h000F2);
        check("t1_cyc6", 64'(cyc), 64'(6));
        check("t1_wren1", 64'(vfs_wren_o), 64'(2'b10));
        step();
        serve("t1_l2", 10'd12, 1, 20'h00044, 20'h000F4);
        check("t1_cyc9", 64'(cyc), 64'(9));
        check("t1_wren_use", 64'(vfs_wren_o), 64'(2'b11));
        check("t1_valid", 64'(vfs_valid_o), 64'(3'b111));
        vfs_selected_i    = 2'd1;
        vfs_broken_bits_i = 20'hABCDE;
        step();
        check("t1_capture_wren", 64'(vfs_wren_o), 64'(0));
        check("t1_capture_dv", 64'(done_valid_o), 64'(0));
        step();
        vfs_selected_i    = 2'd3;
        vfs_broken_bits_i = '0;
        check("t1_done_valid_c11", 64'(done_valid_o), 64'(1));
        check("t1_done_var", 64'(done_var_o), 64'(9));
        check("t1_done_row", 64'(done_row_o), 64'(1));
        check("t1_done_bb", 64'(done_broken_bits_o), 64'(20'hABCDE));

        // Stall in DONE with start pulsed: nothing moves
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            step();
            check("stall_dv", 64'(done_valid_o), 64'(1));
            check("stall_var", 64'(done_var_o), 64'(9));
            check("stall_row", 64'(done_row_o), 64'(1));
            check("stall_start_ready", 64'(start_ready_o), 64'(0));
            check("stall_mem_req", 64'(mem_req_o), 64'(0));
        end
        // Simultaneous ready and start: done accepted, start ignored
        done_ready_i  = 1'b1;
        start_i       = 1'b1;
        clause_vars_i = {10'd1, 10'd1, 10'd1};
        step();
        done_ready_i = 1'b0;
        start_i      = 1'b0;
        check("hs_dv_low", 64'(done_valid_o), 64'(0));
        check("hs_start_ready", 64'(start_ready_o), 64'(1));
        check("hs_no_fetch", 64'(mem_req_o), 64'(0));
        step();
        check("hs_idle_no_fetch", 64'(mem_req_o), 64'(0));
        check("hs_idle_ready", 64'(start_ready_o), 64'(1));

        // Vars {7,0,3}, L=0: literal 1 is padded
        accept(10'd3, 10'd0, 10'd7);
        check("t2_valid_cleared", 64'(vfs_valid_o), 64'(0));
        serve("t2_l0", 10'd7, 0, 20'h12345, 20'h0F0F0);
        check("t2_wren0", 64'(vfs_wren_o), 64'(2'b01));
        step();
        check("t2_pad_wren", 64'(vfs_wren_o), 64'(2'b10));
        check("t2_pad_broken", 64'(vfs_broken_o), 64'(0));
        check("t2_pad_mask", 64'(vfs_mask_o), 64'(0));
        check("t2_pad_no_req", 64'(mem_req_o), 64'(0));
        check("t2_cyc3", 64'(cyc), 64'(3));
        step();
        serve("t2_l2", 10'd3, 0, 20'h00100, 20'h00300);
        check("t2_wren_use", 64'(vfs_wren_o), 64'(2'b11));
        check("t2_valid", 64'(vfs_valid_o), 64'(3'b101));
        vfs_selected_i    = 2'd2;
        vfs_broken_bits_i = 20'h00077;
        step();
        step();
        check("t2_done_valid", 64'(done_valid_o), 64'(1));
        check("t2_done_var", 64'(done_var_o), 64'(3));
        check("t2_done_row", 64'(done_row_o), 64'(2));
        check("t2_done_bb", 64'(done_broken_bits_o), 64'(20'h00077));
        check("t2_valid_held", 64'(vfs_valid_o), 64'(3'b101));
        done_ready_i = 1'b1;
        step();
        done_ready_i = 1'b0;

        // Vars {0,0,0}: all padded, use cycle suppressed, no candidate
        vfs_selected_i    = 2'd0;
        vfs_broken_bits_i = 20'hFFFFF;
        accept(10'd0, 10'd0, 10'd0);
        check("t3_wren0", 64'(vfs_wren_o), 64'(2'b01));
        check("t3_req0", 64'(mem_req_o), 64'(0));
        step();
        check("t3_wren1", 64'(vfs_wren_o), 64'(2'b10));
        check("t3_req1", 64'(mem_req_o), 64'(0));
        step();
        check("t3_wren_suppressed", 64'(vfs_wren_o), 64'(0));
        check("t3_req2", 64'(mem_req_o), 64'(0));
        step();
        check("t3_capture_wren", 64'(vfs_wren_o), 64'(0));
        step();
        check("t3_done_valid", 64'(done_valid_o), 64'(1));
        check("t3_done_var", 64'(done_var_o), 64'(0));
        check("t3_done_row", 64'(done_row_o), 64'(3));
        check("t3_done_bb", 64'(done_broken_bits_o), 64'(0));
        done_ready_i = 1'b1;
        step();
        done_ready_i = 1'b0;

        // Reset during FETCH(1); later responses are ignored
        accept(10'd8, 10'd6, 10'd4);
        serve("t4_l0", 10'd4, 0, 20'h00005, 20'h00006);
        step();
        check("t4_fetch1_req", 64'(mem_req_o), 64'(1));
        check("t4_fetch1_addr", 64'(mem_addr_o), 64'(6));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_rst_req", 64'(mem_req_o), 64'(0));
        check("t4_rst_start_ready", 64'(start_ready_o), 64'(1));
        check("t4_rst_valid", 64'(vfs_valid_o), 64'(0));
        check("t4_rst_broken", 64'(vfs_broken_o), 64'(0));
        check("t4_rst_mask", 64'(vfs_mask_o), 64'(0));
        check("t4_rst_addr", 64'(mem_addr_o), 64'(0));
        mem_rvalid_i = 1'b1;
        mem_broken_i = 20'h0BEEF;
        mem_mask_i   = 20'h0CAFE;
        step();
        step();
        mem_rvalid_i = 1'b0;
        mem_broken_i = '0;
        mem_mask_i   = '0;
        check("t4_late_wren", 64'(vfs_wren_o), 64'(0));
        check("t4_late_broken", 64'(vfs_broken_o), 64'(0));
        check("t4_late_valid", 64'(vfs_valid_o), 64'(0));
        check("t4_late_idle", 64'(start_ready_o), 64'(1));
        check("t4_late_dv", 64'(done_valid_o), 64'(0));

`ifdef FLIP_SEQ_TIMEOUT_EN
        // Literal 0 never answers: request held exactly 4 cycles, then treated as padded
        accept(10'd0, 10'd0, 10'd5);
        for (int i = 0; i < 4; i++) begin
            check("t5_req_high", 64'(mem_req_o), 64'(1));
            step();
        end
        check("t5_req_dropped", 64'(mem_req_o), 64'(0));
        check("t5_wren0", 64'(vfs_wren_o), 64'(2'b01));
        check("t5_valid0", 64'(vfs_valid_o), 64'(0));
        check("t5_broken0", 64'(vfs_broken_o), 64'(0));
        step();
        check("t5_wren1", 64'(vfs_wren_o), 64'(2'b10));
        step();
        check("t5_wren_suppressed", 64'(vfs_wren_o), 64'(0));
        step();
        step();
        check("t5_done_var", 64'(done_var_o), 64'(0));
        check("t5_done_row", 64'(done_row_o), 64'(3));
        done_ready_i = 1'b1;
        step();
        done_ready_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flip_select_sequencer.md
# flip_select_sequencer

- Sequences one variable-flip decision through the flip selector datapath for a chosen unsatisfied clause.
- For each of the NSAT literals, it fetches that variable's broken-clause and mask bits from the occurrence memory.
- It presents each literal to the selector on its own write-enable code, then issues the all-ones "use" cycle.
- It captures the selected row and its broken-clause bits, and returns the chosen variable to the solver top FSM with a valid/ready handshake.

## Interface
Parameters:
- NSAT, 3, literals per clause; only 3 is legal (wren code space); any other value is an elaboration error.
- MAX_CLAUSES_PER_VARIABLE, 20, width MC of broken/mask vectors.
- VAR_BITS, 10, variable index width; index 0 = padding/no variable.
- TIMEOUT_CYCLES, 16, memory watchdog limit (only with macro).

Ports (NB = $clog2(NSAT)):
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start_i  in  1  request a decision; accepted when start_i & start_ready_o.
- start_ready_o  out  1  high only in IDLE.
- clause_vars_i  in  NSAT*VAR_BITS  literal k variable at [k*VAR_BITS +: VAR_BITS]; sampled on accept.
- mem_req_o  out  1  occurrence-memory read request; held until mem_rvalid_i.
- mem_addr_o  out  VAR_BITS  variable index being fetched; stable while mem_req_o.
- mem_rvalid_i  in  1  response strobe; ignored unless mem_req_o.
- mem_broken_i  in  MC  clause-broken bits, valid with mem_rvalid_i.
- mem_mask_i  in  MC  occurrence mask bits, valid with mem_rvalid_i.
- vfs_broken_o  out  MC  to selector clause_broken_i.
- vfs_mask_o  out  MC  to selector mask_bits_i.
- vfs_valid_o  out  NSAT  to selector break_values_valid_i.
- vfs_wren_o  out  NB  to selector wren_i.
- vfs_selected_i  in  NB  from selector selected_o.
- vfs_broken_bits_i  in  MC  from selector clause_broken_bits_o.
- done_valid_o  out  1  result valid; held until done_ready_i.
- done_ready_i  in  1  result consumed.
- done_var_o  out  VAR_BITS  variable to flip; 0 = no candidate.
- done_row_o  out  NB  selected literal row.
- done_broken_bits_o  out  MC  broken bits of selected variable.

## Operation
- States: IDLE, FETCH(k), PRESENT(k), CAPTURE, DONE; k = 0..NSAT-1.
- IDLE: on accept, latch clause_vars_i, clear valid vector, k=0, go FETCH(0). If the latched var is 0, go PRESENT(0) directly.
- FETCH(k): mem_req_o=1, mem_addr_o=var[k].
  - On mem_rvalid_i: register broken/mask into vfs_broken_o/vfs_mask_o, set valid[k], load vfs_wren_o, go PRESENT(k).
- Padded literal (var 0): no fetch; vfs_broken_o/vfs_mask_o=0, valid[k]=0.
- PRESENT(k): vfs_wren_o = (1<<k) for k<NSAT-1, all-ones for k=NSAT-1, for exactly this cycle.
  - Next state: FETCH(k+1) (or PRESENT(k+1) if padded), or CAPTURE after k=NSAT-1.
- All-invalid shortcut: if the valid vector is all zero when entering row NSAT-1's present, drive vfs_wren_o=0 that cycle and force "no candidate".
- vfs_wren_o=0 in all other states. vfs_valid_o is the accumulated valid vector, held until the next accept.
- CAPTURE: sample vfs_selected_i and vfs_broken_bits_i.
  - If selected ≥ NSAT or no candidate: done_var_o=0, done_row_o=NSAT, done_broken_bits_o=0.
  - Else: done_var_o=var[selected].
  - Go DONE.
- DONE: done_valid_o=1; outputs stable; on done_ready_i go IDLE (start_ready_o rises next cycle).
- A start_i asserted outside IDLE is not accepted and not queued.

## Timing
- Reset values: start_ready_o=1, mem_req_o=0, mem_addr_o=0, vfs_*=0, done_valid_o=0, done_var_o=0, done_row_o=NSAT, done_broken_bits_o=0; state IDLE.
- All outputs are registered.
- Memory latency L = cycles after the first req cycle until rvalid (L≥0).
  - Fetched literal costs L+2 cycles; padded literal costs 1 cycle.
- Accept at cycle 0, three fetched literals: done_valid_o first high at cycle 3(L+2)+2 (L=1 → cycle 11).
- Reset mid-operation: next cycle is IDLE with reset values; mem_req_o drops, and any in-flight response is ignored.
- Simultaneous done_ready_i and start_i in DONE: done accepted; start is not accepted that cycle.

## Configuration
- FLIP_SEQ_TIMEOUT_EN defined:
  - FETCH counts cycles; if no mem_rvalid_i by TIMEOUT_CYCLES cycles, drop mem_req_o (the memory cancels).
  - Treat the literal as padded: valid[k]=0, zero data, go PRESENT(k).
- FLIP_SEQ_TIMEOUT_EN undefined: no counter; FETCH waits indefinitely.

## Test plan
- Vars {5,9,12}, L=1, selector returns row 1 → mem_addr_o sequence 5,9,12; vfs_wren_o 01, 10, 11 on cycles 3, 6, 9; done_valid_o at 11 with done_var_o=9, done_row_o=1.
- Vars {7,0,3}, L=0 → no fetch for literal 1; vfs_valid_o=3'b101 on the use cycle; vfs_broken_o/vfs_mask_o=0 during PRESENT(1).
- Vars {0,0,0} → no mem_req_o; vfs_wren_o never 11; done_var_o=0, done_row_o=3.
- done_ready_i held low 5 cycles, start_i pulsed meanwhile → outputs stable, start_ready_o=0, no new fetch; IDLE one cycle after ready.
- Reset asserted during FETCH(1) → next cycle all reset values; a later mem_rvalid_i causes no state change.
- With FLIP_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=4, no response for literal 0 → mem_req_o high exactly 4 cycles, then valid[0]=0 and the sequence continues.
